set_job_scheduler: RTL and testbench

SET_JOB_SCHEDULER -- requirements
Module: set_job_scheduler

---
 rtl/set_job_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_set_job_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_job_scheduler.sv
// set_job_scheduler: two requesters share one set-count engine.
// Jobs are arbitrated round-robin into a small FIFO. A four-state FSM
// issues the oldest job to the engine, waits for its result (or gives up
// after TIMEOUT cycles) and holds the response until it is consumed.
module set_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] req0_central,
    input  logic [11:0] req0_radius,
    input  logic [1:0]  req0_mode,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_central,
    input  logic [11:0] req1_radius,
    input  logic [1:0]  req1_mode,

    output logic        eng_en,
    output logic [23:0] eng_central,
    output logic [11:0] eng_radius,
    output logic [1:0]  eng_mode,
    input  logic        eng_busy,
    input  logic        eng_valid,
    input  logic [7:0]  eng_candidate,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [7:0]  rsp_candidate
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [10:0]   TO_LIMIT   = 11'(TIMEOUT);
    localparam logic [10:0]   TO_LAST    = 11'(TIMEOUT - 1);

    typedef struct packed {
        logic        id;
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } job_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    job_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    job_t          head;

    logic          rr;
    logic          grant0;
    logic          grant1;
    logic          room;
    logic          push;
    logic          pop;
    job_t          push_job;

    state_t        state;
    state_t        state_next;
    logic [10:0]   wait_cnt;
    logic          timed_out;
    logic          load_ops;

    logic          op_id;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];

    // Round-robin grant; a pop in this cycle frees a slot so a full FIFO can still accept
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~rr);
        grant1     = req1_valid & (~req0_valid | rr);
        room       = ~full | pop;
        req0_ready = grant0 & room;
        req1_ready = grant1 & room;
        push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (grant0) begin
            push_job.id      = 1'b0;
            push_job.central = req0_central;
            push_job.radius  = req0_radius;
            push_job.mode    = req0_mode;
        end else begin
            push_job.id      = 1'b1;
            push_job.central = req1_central;
            push_job.radius  = req1_radius;
            push_job.mode    = req1_mode;
        end
    end

    // Priority pointer only moves when a contested grant is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (push && req0_valid && req1_valid) begin
            rr <= ~rr;
        end
    end

    // Job storage; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_job;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Next-state logic plus the engine strobe, response valid and FIFO pop
    always_comb begin
        state_next = state;
        eng_en     = 1'b0;
        rsp_valid  = 1'b0;
        pop        = 1'b0;
        load_ops   = 1'b0;
        timed_out  = (wait_cnt >= TO_LAST);
        case (state)
            S_IDLE: begin
                if (!empty && !eng_busy) begin
                    load_ops   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_en = ~eng_busy;
                if (!eng_busy) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_valid || timed_out) begin
                    pop        = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter: cleared while issuing, counts WAIT cycles, saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            if (wait_cnt != TO_LIMIT) begin
                wait_cnt <= wait_cnt + 11'd1;
            end
        end
    end

    // Operand registers hold the issued job steady because the engine result follows mode live
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_central <= '0;
            eng_radius  <= '0;
            eng_mode    <= '0;
            op_id       <= 1'b0;
        end else if (load_ops) begin
            eng_central <= head.central;
            eng_radius  <= head.radius;
            eng_mode    <= head.mode;
            op_id       <= head.id;
        end
    end

    // Response capture on leaving WAIT; a real result wins over a coincident timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id        <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_candidate <= '0;
        end else if (state == S_WAIT && (eng_valid || timed_out)) begin
            rsp_id <= op_id;
            if (eng_valid) begin
                rsp_err       <= 1'b0;
                rsp_candidate <= eng_candidate;
            end else begin
                rsp_err       <= 1'b1;
                rsp_candidate <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_set_job_scheduler.sv
// Directed testbench for set_job_scheduler. Two instances share stimulus:
// u_main has a long timeout for normal jobs, u_to has TIMEOUT=15 for the
// abort path. Inputs change on the falling edge; outputs are sampled there.
module tb_set_job_scheduler;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [23:0] req0_central;
    logic [11:0] req0_radius;
    logic [1:0]  req0_mode;
    logic        req1_valid;
    logic [23:0] req1_central;
    logic [11:0] req1_radius;
    logic [1:0]  req1_mode;
    logic        eng_busy;
    logic        eng_valid;
    logic [7:0]  eng_candidate;
    logic        rsp_ready;

    logic        m_req0_ready, m_req1_ready, m_eng_en, m_rsp_valid, m_rsp_id, m_rsp_err;
    logic [23:0] m_eng_central;
    logic [11:0] m_eng_radius;
    logic [1:0]  m_eng_mode;
    logic [7:0]  m_rsp_candidate;

    logic        t_req0_ready, t_req1_ready, t_eng_en, t_rsp_valid, t_rsp_id, t_rsp_err;
    logic [23:0] t_eng_central;
    logic [11:0] t_eng_radius;
    logic [1:0]  t_eng_mode;
    logic [7:0]  t_rsp_candidate;

    int errors = 0;
    int checks = 0;
    int m_en_count = 0;
    int base;

    set_job_scheduler #(.DEPTH(4), .TIMEOUT(2047)) u_main (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(m_req0_ready), .req0_central(req0_central),
        .req0_radius(req0_radius), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(m_req1_ready), .req1_central(req1_central),
        .req1_radius(req1_radius), .req1_mode(req1_mode),
        .eng_en(m_eng_en), .eng_central(m_eng_central), .eng_radius(m_eng_radius),
        .eng_mode(m_eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_candidate(eng_candidate),
        .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(m_rsp_id),
        .rsp_err(m_rsp_err), .rsp_candidate(m_rsp_candidate)
    );

    set_job_scheduler #(.DEPTH(4), .TIMEOUT(15)) u_to (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(t_req0_ready), .req0_central(req0_central),
        .req0_radius(req0_radius), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(t_req1_ready), .req1_central(req1_central),
        .req1_radius(req1_radius), .req1_mode(req1_mode),
        .eng_en(t_eng_en), .eng_central(t_eng_central), .eng_radius(t_eng_radius),
        .eng_mode(t_eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_candidate(eng_candidate),
        .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(t_rsp_id),
        .rsp_err(t_rsp_err), .rsp_candidate(t_rsp_candidate)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count engine start pulses of the main instance
    always @(negedge clk) begin
        if (m_eng_en) m_en_count++;
    end

    // Hard stop in case something hangs
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v0, input logic [11:0] r0, input logic v1, input logic [11:0] r1);
        req0_valid   = v0;
        req0_radius  = r0;
        req0_central = {12'h0A0, r0};
        req0_mode    = r0[1:0];
        req1_valid   = v1;
        req1_radius  = r1;
        req1_central = {12'h0B0, r1};
        req1_mode    = r1[1:0];
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);
        eng_busy = 1'b0;
        eng_valid = 1'b0;
        eng_candidate = 8'h00;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic waitEnMain(input string tag, input int budget);
        int n = 0;
        while (!m_eng_en && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, {31'd0, m_eng_en}, 32'd1);
    endtask

    task automatic waitEnTo(input string tag, input int budget);
        int n = 0;
        while (!t_eng_en && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, {31'd0, t_eng_en}, 32'd1);
    endtask

    // Issue-to-response handshake on the main instance with an expected job
    task automatic serviceJob(input string tag, input logic exp_id, input logic [11:0] exp_radius, input logic [7:0] cand);
        waitEnMain({tag, "_en"}, 8);
        checkOutput({tag, "_radius"}, {20'd0, m_eng_radius}, {20'd0, exp_radius});
        step();
        eng_valid = 1'b1;
        eng_candidate = cand;
        step();
        eng_valid = 1'b0;
        checkOutput({tag, "_rsp"}, {21'd0, m_rsp_valid, m_rsp_id, m_rsp_err, m_rsp_candidate},
                    {21'd0, 1'b1, exp_id, 1'b0, cand});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        applyReset();
        checkOutput("rst_outputs", {20'd0, m_eng_en, m_rsp_valid, m_rsp_id, m_rsp_err, m_rsp_candidate}, 32'd0);
        checkOutput("rst_operands", {6'd0, m_eng_mode, m_eng_radius, m_eng_central[11:0]}, 32'd0);
        checkOutput("rst_central_hi", {20'd0, m_eng_central[23:12]}, 32'd0);

        // Single job with a slow engine
        base = m_en_count;
        req0_valid = 1'b1;
        req0_central = 24'h444666;
        req0_radius = 12'h333;
        req0_mode = 2'd0;
        #1 checkOutput("single_ready", {31'd0, m_req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        checkOutput("single_en_early", {31'd0, m_eng_en}, 32'd0);
        step();
        checkOutput("single_en", {31'd0, m_eng_en}, 32'd1);
        checkOutput("single_central", {8'd0, m_eng_central}, 32'h00444666);
        checkOutput("single_radius_mode", {18'd0, m_eng_radius, m_eng_mode}, {18'd0, 12'h333, 2'd0});
        step();
        repeat (1199) step();
        checkOutput("single_no_rsp", {31'd0, m_rsp_valid}, 32'd0);
        checkOutput("single_op_hold", {8'd0, m_eng_central}, 32'h00444666);
        eng_valid = 1'b1;
        eng_candidate = 8'd29;
        step();
        eng_valid = 1'b0;
        checkOutput("single_rsp", {21'd0, m_rsp_valid, m_rsp_id, m_rsp_err, m_rsp_candidate},
                    {21'd0, 1'b1, 1'b0, 1'b0, 8'd29});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("single_rsp_done", {31'd0, m_rsp_valid}, 32'd0);
        #1 checkOutput("single_pulses", m_en_count - base, 32'd1);

        // Lone requester does not move the priority pointer
        applyReset();
        eng_busy = 1'b1;
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h011);
        #1 checkOutput("lone_req1", {30'd0, m_req0_ready, m_req1_ready}, 32'b01);
        step();
        applyStimulus(1'b1, 12'h012, 1'b1, 12'h013);
        #1 checkOutput("lone_then_both", {30'd0, m_req0_ready, m_req1_ready}, 32'b10);
        step();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);

        // Contention: acceptance 0,1,0,1 and responses in the same order
        applyReset();
        eng_busy = 1'b1;
        applyStimulus(1'b1, 12'h101, 1'b1, 12'h201);
        #1 checkOutput("cont_c0", {30'd0, m_req0_ready, m_req1_ready}, 32'b10);
        step();
        applyStimulus(1'b1, 12'h102, 1'b1, 12'h201);
        #1 checkOutput("cont_c1", {30'd0, m_req0_ready, m_req1_ready}, 32'b01);
        step();
        applyStimulus(1'b1, 12'h102, 1'b1, 12'h202);
        #1 checkOutput("cont_c2", {30'd0, m_req0_ready, m_req1_ready}, 32'b10);
        step();
        applyStimulus(1'b1, 12'h103, 1'b1, 12'h202);
        #1 checkOutput("cont_c3", {30'd0, m_req0_ready, m_req1_ready}, 32'b01);
        step();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);
        eng_busy = 1'b0;
        serviceJob("cont_j0", 1'b0, 12'h101, 8'h10);
        serviceJob("cont_j1", 1'b1, 12'h201, 8'h11);
        serviceJob("cont_j2", 1'b0, 12'h102, 8'h12);
        serviceJob("cont_j3", 1'b1, 12'h202, 8'h13);

        // Full FIFO with the engine stalled, then push and pop together
        applyReset();
        eng_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 12'(k), 1'b0, 12'h0);
            #1 checkOutput($sformatf("full_push%0d", k), {31'd0, m_req0_ready}, 32'd1);
            step();
        end
        applyStimulus(1'b1, 12'h005, 1'b0, 12'h0);
        #1 checkOutput("full_block", {31'd0, m_req0_ready}, 32'd0);
        step();
        checkOutput("full_block2", {31'd0, m_req0_ready}, 32'd0);
        eng_busy = 1'b0;
        step();
        checkOutput("full_issue", {31'd0, m_eng_en}, 32'd1);
        checkOutput("full_issue_ready", {31'd0, m_req0_ready}, 32'd0);
        step();
        eng_valid = 1'b1;
        eng_candidate = 8'hA1;
        #1 checkOutput("full_pop_ready", {31'd0, m_req0_ready}, 32'd1);
        step();
        eng_valid = 1'b0;
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);
        checkOutput("full_rsp", {21'd0, m_rsp_valid, m_rsp_id, m_rsp_err, m_rsp_candidate},
                    {21'd0, 1'b1, 1'b0, 1'b0, 8'hA1});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        serviceJob("full_j2", 1'b0, 12'h002, 8'hA2);
        serviceJob("full_j3", 1'b0, 12'h003, 8'hA3);
        serviceJob("full_j4", 1'b0, 12'h004, 8'hA4);
        serviceJob("full_j5", 1'b0, 12'h005, 8'hA5);

        // Timeout path on the TIMEOUT=15 instance
        applyReset();
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h055);
        #1 checkOutput("to_ready", {31'd0, t_req1_ready}, 32'd1);
        step();
        applyStimulus(1'b1, 12'h066, 1'b0, 12'h0);
        step();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);
        waitEnTo("to_en", 4);
        checkOutput("to_radius", {20'd0, t_eng_radius}, 32'h055);
        repeat (15) step();
        checkOutput("to_not_yet", {31'd0, t_rsp_valid}, 32'd0);
        step();
        checkOutput("to_rsp", {21'd0, t_rsp_valid, t_rsp_id, t_rsp_err, t_rsp_candidate},
                    {21'd0, 1'b1, 1'b1, 1'b1, 8'h00});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        waitEnTo("to_next_en", 4);
        checkOutput("to_next_radius", {20'd0, t_eng_radius}, 32'h066);

        // Response backpressure
        applyReset();
        applyStimulus(1'b1, 12'h007, 1'b0, 12'h0);
        step();
        applyStimulus(1'b1, 12'h008, 1'b0, 12'h0);
        step();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);
        waitEnMain("bp_en", 4);
        checkOutput("bp_radius", {20'd0, m_eng_radius}, 32'h007);
        step();
        eng_valid = 1'b1;
        eng_candidate = 8'h5A;
        step();
        eng_valid = 1'b0;
        eng_candidate = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp_hold%0d", i),
                        {8'd0, m_eng_radius, m_eng_en, m_rsp_valid, m_rsp_id, m_rsp_err, m_rsp_candidate},
                        {8'd0, 12'h007, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A});
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        waitEnMain("bp_next_en", 4);
        checkOutput("bp_next_radius", {20'd0, m_eng_radius}, 32'h008);

        // Reset during WAIT followed by a stray engine result
        applyReset();
        applyStimulus(1'b1, 12'h009, 1'b0, 12'h0);
        step();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0);
        waitEnMain("rw_en", 4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 base = m_en_count;
        eng_valid = 1'b1;
        eng_candidate = 8'h77;
        step();
        eng_valid = 1'b0;
        repeat (3) step();
        checkOutput("rw_no_rsp", {31'd0, m_rsp_valid}, 32'd0);
        checkOutput("rw_ops_clear", {20'd0, m_eng_radius}, 32'd0);
        #1 checkOutput("rw_no_issue", m_en_count - base, 32'd0);
        req0_valid = 1'b1;
        #1 checkOutput("rw_ready0", {31'd0, m_req0_ready}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1 checkOutput("rw_ready1", {31'd0, m_req1_ready}, 32'd1);
        req1_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
